// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
// Size codes and FSM state encodings.
package data_mem_responder_pkg;

    localparam logic [1:0] DQM_BYTE = 2'b00;
    localparam logic [1:0] DQM_HALF = 2'b01;
    localparam logic [1:0] DQM_WORD = 2'b10;
    localparam logic [1:0] DQM_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_lane_decode.sv
// Byte-lane decode for stores: byte enables, lane-replicated
// write word and misalignment flag from size and low address bits.
module mem_lane_decode
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  i_dqm,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic        o_misalign
);

    // Reserved size yields no lanes; the top flags it separately.
    always_comb begin
        o_be       = 4'b0000;
        o_wword    = 32'h0;
        o_misalign = 1'b0;
        unique case (i_dqm)
            DQM_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
            end
            DQM_HALF: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword    = {2{i_wdata[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            DQM_WORD: begin
                o_be       = 4'b1111;
                o_wword    = i_wdata;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store port: one request at
// a time, WAIT_STATES delay, byte-lane stores, held response.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_dqm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
    localparam logic [3:0]  WLOAD = 4'(WAIT_STATES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_dqm;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic          w_misalign;
    logic          w_range_err;
    logic          w_err;
    logic          w_fire;
    logic          w_commit;
    logic [AW-1:0] w_idx;

    mem_lane_decode u_lane (
        .i_dqm      (r_dqm),
        .i_addr_lo  (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_misalign (w_misalign)
    );

    assign w_idx       = r_addr[AW+1:2];
    assign w_range_err = ({1'b0, r_addr} >= LIMIT);
    assign w_err       = w_misalign | (r_dqm == DQM_RSVD) | w_range_err;
    assign w_fire      = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_commit    = w_fire && r_write && !w_err;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // Request FSM; WAIT always holds WAIT_STATES+1 cycles so the
    // array access lands WAIT_STATES+1 edges after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_dqm       <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_dqm   <= req_dqm;
                        r_cnt   <= WLOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_err       <= w_err;
                        r_rdata     <= (r_write || w_err) ? 32'h0
                                                          : r_mem[w_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rdata     <= 32'h0;
                        r_err       <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Data array with per-byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

endmodule
